// File: rtl/full_adder_pkg.sv
// Shared constants and types for the ripple-carry full adder.
// The optional signed-overflow outputs are enabled by FULL_ADDER_OVF_EN.
package full_adder_pkg;

  // Widest operand the adder is intended to be built with.
  localparam int FA_MAX_WIDTH     = 64;
  // A single-bit classic full adder when no width is given.
  localparam int FA_DEFAULT_WIDTH = 1;

  // One link of the internal carry chain.
  typedef logic fa_carry_t;

endpackage : full_adder_pkg

// File: rtl/fa_bit.sv
// Single-bit full-adder cell, purely combinational.
// Chained through the carry vector of the full_adder top.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : fa_bit

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder: {cout,sum} = a + b + cin.
// sum/cout are combinational; sum_q/cout_q are a one-cycle registered copy
// cleared asynchronously by rst.
// Optional macro FULL_ADDER_OVF_EN adds signed overflow outputs ovf/ovf_q.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH  // legal range 1..FA_MAX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
`ifdef FULL_ADDER_OVF_EN
  output logic             cout_q,
  output logic             ovf,
  output logic             ovf_q
`else
  output logic             cout_q
`endif
);

  // Carry chain: c[0] is the carry-in, c[WIDTH] the carry-out.
  fa_carry_t c [0:WIDTH];

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      fa_bit u_bit (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (c[gi]),
        .s  (sum[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  assign cout = c[WIDTH];

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH = 1 the carry into the sign bit is cin itself (c[0]).
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  // Registered result stage, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end
`else
  // Registered result stage, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end
`endif

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: WIDTH=1 truth table, WIDTH=8 directed
// corners and register/reset behaviour, WIDTH=16 randomized vectors against
// an arithmetic reference model. Honours FULL_ADDER_OVF_EN when defined.
`timescale 1ns/1ps
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // WIDTH = 1 instance
  logic [0:0] a1 = '0, b1 = '0, sum1, sum_q1;
  logic       cin1 = 1'b0, cout1, cout_q1;
  // WIDTH = 8 instance
  logic [7:0] a8 = '0, b8 = '0, sum8, sum_q8;
  logic       cin8 = 1'b0, cout8, cout_q8;
  // WIDTH = 16 instance
  logic [15:0] a16 = '0, b16 = '0, sum16, sum_q16;
  logic        cin16 = 1'b0, cout16, cout_q16;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf_q1, ovf8, ovf_q8, ovf16, ovf_q16;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_fa1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1),
`ifdef FULL_ADDER_OVF_EN
    .cout_q(cout_q1), .ovf(ovf1), .ovf_q(ovf_q1)
`else
    .cout_q(cout_q1)
`endif
  );

  full_adder #(.WIDTH(8)) u_fa8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .sum_q(sum_q8),
`ifdef FULL_ADDER_OVF_EN
    .cout_q(cout_q8), .ovf(ovf8), .ovf_q(ovf_q8)
`else
    .cout_q(cout_q8)
`endif
  );

  full_adder #(.WIDTH(16)) u_fa16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .sum_q(sum_q16),
`ifdef FULL_ADDER_OVF_EN
    .cout_q(cout_q16), .ovf(ovf16), .ovf_q(ovf_q16)
`else
    .cout_q(cout_q16)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: exact (WIDTH+1)-bit sum of unsigned operands.
  function automatic logic [16:0] ref_add16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    return 17'(x) + 17'(y) + 17'(ci);
  endfunction

  // Reference model: signed overflow as "true signed result out of range".
  function automatic logic ref_ovf(input longint x, input longint y, input logic ci, input int w);
    longint r, lo, hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    r  = x + y + longint'(ci);
    return (r > hi) || (r < lo);
  endfunction

  // Expected registered WIDTH=16 result: previous cycle's exact sum, zero in reset.
  logic [16:0] exp_q16 = '0;
  logic        exp_ovf_q16 = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q16     <= '0;
      exp_ovf_q16 <= 1'b0;
    end else begin
      exp_q16     <= ref_add16(a16, b16, cin16);
      exp_ovf_q16 <= ref_ovf(longint'($signed(a16)), longint'($signed(b16)), cin16, 16);
    end
  end

  // Compare process for the randomized WIDTH=16 phase, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("w16_sum_cout", {cout16, sum16}, ref_add16(a16, b16, cin16));
      chk("w16_sum_cout_q", {cout_q16, sum_q16}, exp_q16);
`ifdef FULL_ADDER_OVF_EN
      chk("w16_ovf", ovf16, ref_ovf(longint'($signed(a16)), longint'($signed(b16)), cin16, 16));
      chk("w16_ovf_q", ovf_q16, exp_ovf_q16);
`endif
    end
  end

  initial begin
    logic [1:0] tbl [8];
    logic [2:0] v;
    // {sum,cout} for {a,b,cin} = 0..7
    tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    // WIDTH=1 truth table, no clock dependence
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      #5;
      chk("w1_table", {sum1, cout1}, tbl[i]);
      chk("w1_model", {cout1, sum1}, 2'(a1) + 2'(b1) + 2'(cin1));
`ifdef FULL_ADDER_OVF_EN
      chk("w1_ovf", ovf1, ref_ovf(longint'($signed(a1)), longint'($signed(b1)), cin1, 1));
`endif
    end

    // Registered stage held at zero while rst is high, across a clock edge
    @(posedge clk); #1;
    chk("reset_sum_q8", sum_q8, 8'h00);
    chk("reset_cout_q8", cout_q8, 1'b0);
    chk("reset_sum_q16", sum_q16, 16'h0000);

    // WIDTH=8 combinational corners (also valid while in reset)
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
    chk("w8_ripple", {cout8, sum8}, 9'h100);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
    chk("w8_wrap", {cout8, sum8}, 9'h1FF);

    // Registered path
    @(negedge clk);
    rst = 1'b0;
    a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b0;
    @(posedge clk); #1;
    chk("reg_capture", {cout_q8, sum_q8}, 9'h041);
    a8 = 8'h10; b8 = 8'h10; #2;
    chk("reg_hold", sum_q8, 8'h41);
    chk("reg_hold_comb", sum8, 8'h20);
    a8 = 8'h3C; b8 = 8'h05;
    @(negedge clk); #1;
    rst = 1'b1; #1;
    chk("async_rst_sum_q", sum_q8, 8'h00);
    chk("async_rst_cout_q", cout_q8, 1'b0);
    chk("async_rst_comb", sum8, 8'h41);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("recapture", {cout_q8, sum_q8}, 9'h041);

`ifdef FULL_ADDER_OVF_EN
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; #1;
    chk("ovf_pos_sum", sum8, 8'h80);
    chk("ovf_pos", ovf8, 1'b1);
    a8 = 8'h80; b8 = 8'hFF; cin8 = 1'b0; #1;
    chk("ovf_neg", {cout8, ovf8, sum8}, 10'h37F);
    a8 = 8'h05; b8 = 8'hFB; cin8 = 1'b0; #1;
    chk("ovf_none", {ovf8, sum8}, 9'h000);
    @(posedge clk); #1;
    chk("ovf_q_none", ovf_q8, 1'b0);
`endif

    // Randomized WIDTH=16 phase with occasional asynchronous resets
    @(posedge clk); #1;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    chk_en = 1'b1;
    repeat (10000) begin
      @(posedge clk); #1;
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder
